// File: rtl/spi_master.sv
// SPI master (mode 0): sends a 16-bit frame {addr[6:0], rw, data[7:0]} MSB first.
// On a read, the last 8 bits are captured from miso and returned on rdata.
module spi_master #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic [7:0] rdata,
   output logic       sclk,
   output logic       cs,
   output logic       mosi,
   input  logic       miso
);

   localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned CNT_W = 5;

   generate
      if (CLK_DIV < 2) begin : g_bad_div
         $error("spi_master: CLK_DIV must be >= 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      HOLD,
      GAP
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [DIV_W-1:0] div_cnt;
   logic [CNT_W-1:0] bit_cnt;
   logic [15:0]      sr;
   logic [7:0]       rx;
   logic             rw_q;
   logic             phase_end_c;

   assign phase_end_c = (div_cnt == DIV_W'(CLK_DIV - 1));

   // The shift register empties to zero after 16 shifts, so mosi idles low.
   assign mosi = sr[15];

   // Next-state logic: every non-IDLE phase lasts CLK_DIV cycles.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = SETUP;
         SETUP:   if (phase_end_c) state_next = HIGH;
         HIGH:    if (phase_end_c) state_next = LOW;
         LOW:     if (phase_end_c) state_next = (bit_cnt == CNT_W'(16)) ? HOLD : HIGH;
         HOLD:    if (phase_end_c) state_next = GAP;
         GAP:     if (phase_end_c) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Datapath and registered pin/handshake outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         bit_cnt <= '0;
         sr      <= '0;
         rx      <= '0;
         rw_q    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         rdata   <= '0;
         sclk    <= 1'b0;
         cs      <= 1'b1;
      end else begin
         done <= 1'b0;
         busy <= (state_next != IDLE);
         sclk <= (state_next == HIGH);
         cs   <= (state_next == IDLE) || (state_next == GAP);

         if ((state == IDLE) || phase_end_c) div_cnt <= '0;
         else                                div_cnt <= div_cnt + DIV_W'(1);

         case (state)
            IDLE: begin
               if (start) begin
                  sr      <= {addr, rw, rw ? 8'h00 : wdata};
                  rw_q    <= rw;
                  bit_cnt <= '0;
                  rx      <= '0;
               end
            end
            HIGH: begin
               // Sample at the end of the high phase; shift out on the falling edge.
               if (phase_end_c) begin
                  if (rw_q && (bit_cnt >= CNT_W'(8))) rx <= {rx[6:0], miso};
                  sr      <= {sr[14:0], 1'b0};
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            GAP: begin
               if (phase_end_c) begin
                  done <= 1'b1;
                  if (rw_q) rdata <= rx;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master.sv
// Randomized self-checking bench for spi_master with a mode-0 slave model
// and a frame-level reference (expected bits, latency, read data).
module tb_spi_master;

   localparam int unsigned CLK_DIV = 4;
   localparam int LAT   = 35 * CLK_DIV;
   localparam int LIMIT = LAT + 20;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       rw;
   logic [6:0] addr;
   logic [7:0] wdata;
   logic       busy;
   logic       done;
   logic [7:0] rdata;
   logic       sclk;
   logic       cs;
   logic       mosi;
   logic       miso;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  slave_byte;
   logic [7:0]  exp_rdata;
   logic [15:0] cap = '0;
   logic        mosi_at_rise = 1'b0;
   int          rises = 0;
   int          hi_viol = 0;
   int          done_cnt = 0;
   int          falls = 0;
   int          cs_run = 0;
   int          last_gap = 0;

   spi_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .rw      (rw),
      .addr    (addr),
      .wdata   (wdata),
      .busy    (busy),
      .done    (done),
      .rdata   (rdata),
      .sclk    (sclk),
      .cs      (cs),
      .mosi    (mosi),
      .miso    (miso)
   );

   always #5 clk = ~clk;

   // Slave: capture mosi on rising sclk, present data bits after each falling edge.
   always @(posedge sclk) begin
      if (!cs) begin
         cap          <= {cap[14:0], mosi};
         rises        <= rises + 1;
         mosi_at_rise <= mosi;
      end
   end

   always @(negedge sclk or posedge cs) begin
      if (cs) falls <= 0;
      else    falls <= falls + 1;
   end

   always_comb begin
      miso = 1'b1;
      if (falls >= 8 && falls <= 15) miso = slave_byte[3'(15 - falls)];
   end

   always @(negedge clk) begin
      if (sclk && (mosi !== mosi_at_rise)) hi_viol <= hi_viol + 1;
      if (cs) cs_run <= cs_run + 1;
      else begin
         if (cs_run != 0) last_gap <= cs_run;
         cs_run <= 0;
      end
   end

   always @(posedge done) done_cnt <= done_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One transaction, entered and left on a negedge of clk.
   task automatic run_frame(input logic f_rw, input logic [6:0] f_addr, input logic [7:0] f_wdata,
                            input logic [7:0] f_sbyte, input bit keep_start, input int mid_cyc,
                            input bit chained);
      int          cyc;
      int          r0;
      int          v0;
      int          d0;
      logic [15:0] exp_bits;
      exp_bits   = {f_addr, f_rw, f_rw ? 8'h00 : f_wdata};
      slave_byte = f_sbyte;
      rw = f_rw; addr = f_addr; wdata = f_wdata; start = 1'b1;
      r0 = rises; v0 = hi_viol; d0 = done_cnt;
      @(posedge clk);
      for (cyc = 0; cyc <= LIMIT; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            chk("busy_accept", busy, 1);
            chk("cs_accept", cs, 0);
            chk("mosi_first", mosi, exp_bits[15]);
            if (!keep_start) start = 1'b0;
            rw = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
         end
         if (!keep_start && mid_cyc != 0 && cyc == mid_cyc) start = 1'b1;
         if (!keep_start && mid_cyc != 0 && cyc == mid_cyc + 1) start = 1'b0;
         if (done) break;
         @(posedge clk);
      end
      chk("latency", cyc, LAT);
      chk("busy_at_done", busy, 0);
      chk("frame_bits", cap, exp_bits);
      chk("sclk_rises", rises - r0, 16);
      if (f_rw) exp_rdata = f_sbyte;
      chk("rdata", rdata, exp_rdata);
      chk("mosi_stable_high", hi_viol - v0, 0);
      if (chained) chk("cs_gap_b2b", last_gap, CLK_DIV + 1);
      else         chk("cs_gap_min", (last_gap >= int'(CLK_DIV)) ? 1 : 0, 1);
      if (!keep_start) begin
         @(posedge clk);
         @(negedge clk);
         chk("done_pulses", done_cnt - d0, 1);
         chk("done_one_cycle", done, 0);
         chk("idle_after", busy, 0);
      end
   endtask

   initial begin
      int d0;
      reset_n = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0;
      slave_byte = '0; exp_rdata = '0;

      // Reset with a start pulse applied: nothing may move.
      repeat (3) @(negedge clk);
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cs", cs, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rdata", rdata, 0);
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_cs", cs, 1);

      run_frame(1'b0, 7'h2A, 8'hC3, 8'h5A, 1'b0, 0, 1'b0);
      run_frame(1'b1, 7'h05, 8'hFF, 8'h96, 1'b0, 0, 1'b0);

      // Back-to-back with start held high across the boundary.
      run_frame(1'b0, 7'h11, 8'h3C, 8'h00, 1'b1, 0, 1'b0);
      run_frame(1'b1, 7'h7F, 8'h00, 8'hA5, 1'b0, 0, 1'b1);

      run_frame(1'b0, 7'h40, 8'h81, 8'h00, 1'b0, 70, 1'b0);

      // Reset during bit 9 of a read.
      slave_byte = 8'h3C; rw = 1'b1; addr = 7'h05; start = 1'b1;
      d0 = done_cnt;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (77) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_cs", cs, 1);
      chk("midrst_sclk", sclk, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_rdata", rdata, 0);
      exp_rdata = 8'h00;
      repeat (4) @(negedge clk);
      chk("midrst_no_done", done_cnt - d0, 0);
      reset_n = 1'b1;
      @(negedge clk);
      run_frame(1'b1, 7'h05, 8'h00, 8'h3C, 1'b0, 0, 1'b0);

      for (int i = 0; i < 12; i++) begin
         int mid;
         mid = ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 120)) : 0;
         run_frame(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 1'b0, mid, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
